// File: rtl/spi_dac_multi.sv
// spi_dac_multi: multi-lane SPI DAC frame generator.
//   Drives NUM_CH DACs in parallel with one shared CS/SCK and one MOSI lane
//   per channel, MSB first. Each frame word is {LEAD_BITS zeros, pd, data}.
//   Frames run continuously (mode_i=0) or only while a channel has a pending
//   update (mode_i=1).
// Ports:
//   clk, rst_ni      clock, asynchronous active-low reset
//   en_i, mode_i     enable / frame mode (sampled at start decision only)
//   data_i, pd_i     per-channel data and power-down slices
//   upd_i            per-channel strobe, writes the holding register
//   spi_cs_no        chip select (active low)
//   spi_sck_o        SPI clock (idle high; DAC samples on falling edge)
//   spi_mosi_o       one MOSI lane per channel
//   pending_o        channel updated since its last frame load
//   busy_o           FSM not idle
//   frame_done_o     1-cycle pulse in the cycle CS rises at frame end
// Optional feature: define SPI_DAC_LDAC_EN to add ldac_no, a HALF_DIV-cycle
//   low pulse starting the cycle after CS rises; a following CS gap is held
//   off until the pulse has run its course.

module spi_dac_lane #(
  parameter int DATA_W     = 12,
  parameter int PD_W       = 2,
  parameter int FRAME_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PD_W-1:0]   pd_i,
  input  logic              load_i,
  input  logic              shift_i,
  output logic              mosi_o,
  output logic              pending_o
);
  logic [DATA_W-1:0]     data_hold_q, data_hold_d;
  logic [PD_W-1:0]       pd_hold_q, pd_hold_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  pend_q, pend_d;
  logic [FRAME_BITS-1:0] load_word;

  // Zero extension supplies the leading zero bits.
  assign load_word = FRAME_BITS'({pd_hold_q, data_hold_q});

  always_comb begin
    data_hold_d = data_hold_q;
    pd_hold_d   = pd_hold_q;
    shreg_d     = shreg_q;
    if (upd_i) begin
      data_hold_d = data_i;
      pd_hold_d   = pd_i;
    end
    // An update in the load cycle wins, so the new value is not lost.
    pend_d = (pend_q & ~load_i) | upd_i;
    if (load_i)       shreg_d = load_word;
    else if (shift_i) shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_hold_q <= '0;
      pd_hold_q   <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
    end else begin
      data_hold_q <= data_hold_d;
      pd_hold_q   <= pd_hold_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
    end
  end

  assign mosi_o    = shreg_q[FRAME_BITS-1];
  assign pending_o = pend_q;
endmodule

module spi_dac_multi #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 12,
  parameter int PD_W      = 2,
  parameter int LEAD_BITS = 2,
  parameter int HALF_DIV  = 15,
  parameter int CS_GAP_HP = 2
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH*PD_W-1:0]   pd_i,
  input  logic [NUM_CH-1:0]        upd_i,
  output logic                     spi_cs_no,
  output logic                     spi_sck_o,
  output logic [NUM_CH-1:0]        spi_mosi_o,
  output logic [NUM_CH-1:0]        pending_o,
  output logic                     busy_o,
  output logic                     frame_done_o
`ifdef SPI_DAC_LDAC_EN
  ,
  output logic                     ldac_no
`endif
);
  localparam int FRAME_BITS = LEAD_BITS + PD_W + DATA_W;
  localparam int HP_W       = $clog2(HALF_DIV + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int GAP_W      = $clog2(CS_GAP_HP + 1);

  typedef enum logic [1:0] {IDLE, CS_GAP, SCK_HIGH, SCK_LOW} state_e;

  state_e            state_q, state_d;
  logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              cs_q, cs_d, sck_q, sck_d, done_q, done_d;
  logic              load, shift, start, hp_last, gap_hold;
  logic [NUM_CH-1:0] pend;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    spi_dac_lane #(.DATA_W(DATA_W), .PD_W(PD_W), .FRAME_BITS(FRAME_BITS)) u_lane (
      .clk      (clk),
      .rst_ni   (rst_ni),
      .upd_i    (upd_i[c]),
      .data_i   (data_i[c*DATA_W +: DATA_W]),
      .pd_i     (pd_i[c*PD_W +: PD_W]),
      .load_i   (load),
      .shift_i  (shift),
      .mosi_o   (spi_mosi_o[c]),
      .pending_o(pend[c])
    );
  end

  assign start   = en_i & (~mode_i | (|pend));
  assign hp_last = (hp_cnt_q == HP_W'(HALF_DIV - 1));

  always_comb begin
    state_d   = state_q;
    // Saturating count; every phase change clears it explicitly below.
    hp_cnt_d  = (hp_cnt_q == HP_W'(HALF_DIV)) ? hp_cnt_q : hp_cnt_q + HP_W'(1);
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_d      = 1'b1;
        sck_d     = 1'b1;
        hp_cnt_d  = '0;
        gap_cnt_d = '0;
        if (start) begin
          load    = 1'b1;
          state_d = CS_GAP;
        end
      end
      CS_GAP: begin
        if (gap_hold) begin
          hp_cnt_d = hp_cnt_q;
        end else if (hp_last) begin
          hp_cnt_d = '0;
          if (gap_cnt_q == GAP_W'(CS_GAP_HP - 1)) begin
            gap_cnt_d = '0;
            cs_d      = 1'b0;
            bit_cnt_d = '0;
            state_d   = SCK_HIGH;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      SCK_HIGH: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          sck_d    = 1'b0;
          state_d  = SCK_LOW;
        end
      end
      SCK_LOW: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          sck_d    = 1'b1;
          if (bit_cnt_q != BIT_W'(FRAME_BITS - 1)) begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            state_d   = SCK_HIGH;
          end else begin
            // Frame end: CS rises with the last SCK rise.
            cs_d      = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            if (start) begin
              load    = 1'b1;
              state_d = CS_GAP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      hp_cnt_q  <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_cnt_q  <= hp_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_DAC_LDAC_EN
  localparam int LC_W = $clog2(HALF_DIV + 2);
  // lcnt runs HALF_DIV+1 .. 1 after a frame end: the first value is the CS
  // rise cycle, the remaining HALF_DIV values are the low pulse.
  logic [LC_W-1:0] lcnt_q, lcnt_d;
  logic            ldac_q, ldac_d;

  always_comb begin
    lcnt_d = lcnt_q;
    if (done_d)              lcnt_d = LC_W'(HALF_DIV + 1);
    else if (lcnt_q != '0)   lcnt_d = lcnt_q - LC_W'(1);
    ldac_d = ~((lcnt_d != '0) && (lcnt_d <= LC_W'(HALF_DIV)));
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lcnt_q <= '0;
      ldac_q <= 1'b1;
    end else begin
      lcnt_q <= lcnt_d;
      ldac_q <= ldac_d;
    end
  end

  // Gap count is frozen for the first HALF_DIV cycles after CS rises.
  assign gap_hold = (lcnt_q > LC_W'(1));
  assign ldac_no  = ldac_q;
  assign busy_o   = (state_q != IDLE) | (lcnt_q != '0);
`else
  assign gap_hold = 1'b0;
  assign busy_o   = (state_q != IDLE);
`endif

  assign spi_cs_no    = cs_q;
  assign spi_sck_o    = sck_q;
  assign pending_o    = pend;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_spi_dac_multi.sv
// Testbench for spi_dac_multi (default parameters).
module tb_spi_dac_multi;
  localparam int H  = 15;
  localparam int G  = 2 * H;
  localparam int FB = 16;
`ifdef SPI_DAC_LDAC_EN
  localparam int LDAC_EXTRA = H;
`else
  localparam int LDAC_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni, en_i, mode_i;
  logic [23:0] data_i;
  logic [3:0]  pd_i;
  logic [1:0]  upd_i;
  logic        spi_cs_no, spi_sck_o, busy_o, frame_done_o;
  logic [1:0]  spi_mosi_o, pending_o;
`ifdef SPI_DAC_LDAC_EN
  logic        ldac_no;
`endif

  spi_dac_multi dut (
    .clk(clk), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i),
    .data_i(data_i), .pd_i(pd_i), .upd_i(upd_i),
    .spi_cs_no(spi_cs_no), .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o),
    .pending_o(pending_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef SPI_DAC_LDAC_EN
    , .ldac_no(ldac_no)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the holding registers, plus a per-cycle history so a frame's
  // expected word can be taken from the cycle its load happened.
  logic [23:0] m_data;
  logic [3:0]  m_pd;
  logic [23:0] h_data [0:4095];
  logic [3:0]  h_pd   [0:4095];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_data <= '0;
      m_pd   <= '0;
    end else begin
      for (int c = 0; c < 2; c++)
        if (upd_i[c]) begin
          m_data[c*12 +: 12] <= data_i[c*12 +: 12];
          m_pd[c*2 +: 2]     <= pd_i[c*2 +: 2];
        end
    end
  end

  // Compare process state.
  logic        p_cs, p_sck, p_busy;
  logic [1:0]  p_mosi;
  int          gap_start, cs_fall_cyc, last_edge, fall_idx, frames, last_rise;
  int          last_gap, last_cs_low, last_falls;
  bit          in_frame;
  logic [15:0] exp_w [2];
  logic [15:0] cap_w [2];
  logic [15:0] last_w [2];

  initial begin
    frames = 0; last_rise = -1000; in_frame = 0; fall_idx = 0;
    gap_start = 0; last_gap = 0; last_cs_low = 0; last_falls = 0;
  end

  always @(negedge clk) begin
    logic cs_rose, cs_fell, sck_rose, sck_fell, busy_rose;
    int   L;
    h_data[cyc % 4096] = rst_ni ? m_data : '0;
    h_pd[cyc % 4096]   = rst_ni ? m_pd : '0;
    if (!rst_ni) begin
      chk("reset_pins", {spi_cs_no, spi_sck_o, spi_mosi_o, busy_o, frame_done_o, pending_o},
          {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00});
      p_cs = 1'b1; p_sck = 1'b1; p_busy = 1'b0; p_mosi = 2'b00;
      in_frame = 0; last_rise = -1000;
    end else begin
      cs_rose   = spi_cs_no & ~p_cs;
      cs_fell   = ~spi_cs_no & p_cs;
      sck_rose  = spi_sck_o & ~p_sck;
      sck_fell  = ~spi_sck_o & p_sck;
      busy_rose = busy_o & ~p_busy;
      chk("frame_done_at_cs_rise", frame_done_o, cs_rose);
      if (!busy_o) chk("idle_pins", {spi_cs_no, spi_sck_o}, 2'b11);
      if (!spi_cs_no) chk("busy_in_frame", busy_o, 1'b1);
      if (spi_mosi_o !== p_mosi)
        chk("mosi_change_point", sck_rose | busy_rose | cs_rose, 1'b1);
      if (busy_rose) gap_start = cyc;
      if (cs_fell) begin
        L = gap_start - 1;
        for (int c = 0; c < 2; c++)
          exp_w[c] = {2'b00, h_pd[L % 4096][c*2 +: 2], h_data[L % 4096][c*12 +: 12]};
        last_gap = cyc - gap_start;
        chk("cs_gap_len", last_gap, G + ((gap_start == last_rise) ? LDAC_EXTRA : 0));
        in_frame = 1; fall_idx = 0; cs_fall_cyc = cyc; last_edge = cyc;
        cap_w[0] = '0; cap_w[1] = '0;
      end
      if (sck_rose | sck_fell) begin
        chk("sck_only_in_frame", in_frame, 1'b1);
        chk("sck_half_period", cyc - last_edge, H);
        last_edge = cyc;
      end
      if (sck_fell && in_frame) begin
        if (fall_idx > FB - 1) chk("extra_sck_fall", fall_idx, FB - 1);
        else
          for (int c = 0; c < 2; c++) begin
            chk("mosi_bit", spi_mosi_o[c], exp_w[c][FB - 1 - fall_idx]);
            cap_w[c] = {cap_w[c][14:0], spi_mosi_o[c]};
          end
        fall_idx++;
      end
      if (cs_rose) begin
        if (in_frame) begin
          chk("falls_per_frame", fall_idx, FB);
          last_cs_low = cyc - cs_fall_cyc;
          chk("cs_low_len", last_cs_low, 2 * FB * H);
          last_falls = fall_idx;
          last_w[0] = cap_w[0]; last_w[1] = cap_w[1];
          frames++;
        end
        in_frame = 0; last_rise = cyc; gap_start = cyc;
      end
`ifdef SPI_DAC_LDAC_EN
      chk("ldac_pulse", ldac_no, ~((cyc > last_rise) && (cyc <= last_rise + H)));
`endif
      p_cs = spi_cs_no; p_sck = spi_sck_o; p_busy = busy_o; p_mosi = spi_mosi_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int f0 = frames;
    int k = 0;
    while (frames < f0 + n && k < budget) begin step(1); k++; end
    chk(name, frames >= f0 + n, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy_o && k < budget) begin step(1); k++; end
    chk(name, busy_o, 1'b0);
  endtask

  task automatic wait_falls(input int n, input int budget, input string name);
    int k = 0;
    while (!(in_frame && fall_idx >= n) && k < budget) begin step(1); k++; end
    chk(name, in_frame && fall_idx >= n, 1'b1);
  endtask

  initial begin
    int f0, busy_low;
    rst_ni = 1'b0; en_i = 1'b0; mode_i = 1'b1;
    data_i = '0; pd_i = '0; upd_i = '0;
    step(3);
    chk("rst_cs_sck", {spi_cs_no, spi_sck_o}, 2'b11);
    chk("rst_mosi_pend", {spi_mosi_o, pending_o}, 4'b0000);
    rst_ni = 1'b1;
    step(5);
    chk("idle_after_rst", busy_o, 1'b0);

    // 1: single on-update frame
    data_i = {12'h3F0, 12'hA5C}; pd_i = {2'b10, 2'b01}; upd_i = 2'b11; en_i = 1'b1;
    f0 = frames;
    step(1);
    upd_i = 2'b00;
    wait_frames(1, 800, "t1_frame_timeout");
    chk("t1_lane0", last_w[0], 16'h1A5C);
    chk("t1_lane1", last_w[1], 16'h23F0);
    chk("t1_cs_low", last_cs_low, 480);
    step(1);
    chk("t1_pending_clear", pending_o, 2'b00);
    wait_idle(100, "t1_idle");
    step(50);
    chk("t1_one_frame", frames, f0 + 1);

    // 2: continuous frames
    mode_i = 1'b0;
    step(2);
    busy_low = 0;
    f0 = frames;
    while (frames < f0 + 3 && busy_low < 2000) begin
      if (!busy_o) busy_low++;
      step(1);
    end
    chk("t2_three_frames", frames, f0 + 3);
    chk("t2_busy_held", busy_low, 0);
    chk("t2_gap", last_gap, G + LDAC_EXTRA);
    chk("t2_lane0", last_w[0], 16'h1A5C);
    chk("t2_lane1", last_w[1], 16'h23F0);
    mode_i = 1'b1;
    wait_idle(700, "t2_idle");

    // 3: update landing in the load cycle
    step(20);
    data_i[11:0] = 12'h222; upd_i = 2'b01;
    step(1);
    data_i[11:0] = 12'h111; upd_i = 2'b01;
    step(1);
    upd_i = 2'b00;
    chk("t3_pending_kept", pending_o, 2'b01);
    chk("t3_busy", busy_o, 1'b1);
    wait_frames(1, 800, "t3_frame1_timeout");
    chk("t3_old_value", last_w[0], 16'h1222);
    wait_frames(1, 800, "t3_frame2_timeout");
    chk("t3_new_value", last_w[0], 16'h1111);
    chk("t3_lane1", last_w[1], 16'h23F0);
    step(1);
    chk("t3_pending_clear", pending_o, 2'b00);
    wait_idle(100, "t3_idle");

    // 4: enable dropped mid-frame
    mode_i = 1'b0;
    f0 = frames;
    wait_falls(5, 800, "t4_reach_fall5");
    en_i = 1'b0;
    wait_frames(1, 800, "t4_frame_timeout");
    chk("t4_all_bits", last_falls, 16);
    wait_idle(100, "t4_idle");
    step(200);
    chk("t4_no_more", frames, f0 + 1);
    chk("t4_busy_low", busy_o, 1'b0);

    // 5: reset mid-frame
    en_i = 1'b1;
    wait_falls(4, 800, "t5_reach_fall4");
    chk("t5_mosi_live", spi_mosi_o[0], 1'b1);
    f0 = frames;
    #1 rst_ni = 1'b0;
    #1;
    chk("t5_async_pins", {spi_cs_no, spi_sck_o, spi_mosi_o, busy_o}, 5'b11000);
    step(3);
    en_i = 1'b0;
    rst_ni = 1'b1;
    step(50);
    chk("t5_idle_after", busy_o, 1'b0);
    en_i = 1'b1; mode_i = 1'b1;
    step(50);
    chk("t5_no_start", {busy_o, spi_cs_no}, 2'b01);
    chk("t5_no_frames", frames, f0);
    data_i[23:12] = 12'h0FF; pd_i[3:2] = 2'b11; upd_i = 2'b10;
    step(1);
    upd_i = 2'b00;
    wait_frames(1, 800, "t5_frame_timeout");
    chk("t5_lane0_cleared", last_w[0], 16'h0000);
    chk("t5_lane1", last_w[1], 16'h30FF);
    wait_idle(100, "t5_final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
